mem_copy_engine: RTL and testbench

Bus master for the single-port 32x16 memory. It drives addr/we/data_in and samples the combinational data_out. It accepts a copy command (source, destination, length) over a valid/ready handshake, copies the words one at a time (one read cycle, then one write cycle), and reports the word count and a running checksum. It sits between the control/test logic and the memory macro and is the only master on that memory port.

---
 rtl/mem_copy_engine.sv | 147 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: single-master copy engine for a single-port memory.
// Accepts a (src, dst, len) command over valid/ready, then copies len words in
// ascending order with one read cycle followed by one write cycle per word.
// Reports the number of words written and a running modular checksum.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   cmd_valid_i/ready_o command handshake (ready only in idle)
//   cmd_src_i/dst_i/len_i first source/destination address, word count
//   abort_i            stop the current copy early
//   mem_addr_o/we_o/wdata_o, mem_rdata_i  memory port (rdata combinational)
//   busy_o, done_o, aborted_o, words_copied_o, checksum_o  status
module mem_copy_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_src_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [LEN_W-1:0]  words_copied_o,
    output logic [DATA_W-1:0] checksum_o
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              aborted_q, aborted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            hold_q    <= '0;
            words_q   <= '0;
            sum_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            hold_q    <= hold_d;
            words_q   <= words_d;
            sum_q     <= sum_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
        words_d   = words_q;
        sum_d     = sum_q;
        aborted_d = aborted_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready is high for the whole idle state, so valid alone fires.
                if (cmd_valid_i) begin
                    src_d     = cmd_src_i;
                    dst_d     = cmd_dst_i;
                    rem_d     = cmd_len_i;
                    words_d   = '0;
                    sum_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (cmd_len_i == '0) ? StDone : StRd;
                end
            end
            StRd: begin
                if (abort_i) begin
                    // Abort during a read drops this word entirely.
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    hold_d  = mem_rdata_i;
                    src_d   = src_q + ADDR_W'(1);
                    state_d = StWr;
                end
            end
            StWr: begin
                // The write in flight always completes and is counted.
                dst_d   = dst_q + ADDR_W'(1);
                rem_d   = rem_q - LEN_W'(1);
                words_d = words_q + LEN_W'(1);
                sum_d   = sum_q + hold_q;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (rem_q == LEN_W'(1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend only on state and registers.
    always_comb begin
        mem_addr_o = '0;
        if (state_q == StRd) begin
            mem_addr_o = src_q;
        end else if (state_q == StWr) begin
            mem_addr_o = dst_q;
        end
    end

    assign mem_we_o       = (state_q == StWr);
    assign mem_wdata_o    = hold_q;
    assign cmd_ready_o    = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign aborted_o      = aborted_q;
    assign words_copied_o = words_q;
    assign checksum_o     = sum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a 64K x 32 memory model, a table of
// directed commands, hand-written reset/overlap sequences and randomized copies
// checked against a sequential per-word reference copy.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = '0;
    logic [15:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        abort = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy, done, aborted;
    logic [15:0] words_copied;
    logic [31:0] checksum;

    logic [31:0] mem     [65536];
    logic [31:0] ref_mem [65536];
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [31:0] tb_wdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_copy_engine #(.ADDR_W(16), .DATA_W(32), .LEN_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_src_i      (cmd_src),
        .cmd_dst_i      (cmd_dst),
        .cmd_len_i      (cmd_len),
        .abort_i        (abort),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .busy_o         (busy),
        .done_o         (done),
        .aborted_o      (aborted),
        .words_copied_o (words_copied),
        .checksum_o     (checksum)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    endtask

    task automatic compare_mem(input string nm);
        int diffs = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(nm, 64'(diffs), 64'd0);
    endtask

    // Issues one command, applies abort during cycle abort_cyc after accept
    // (cycle 1 is the first cycle after the accepting edge; 0 = never) and
    // checks everything against a sequential reference copy.
    task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input int abort_cyc,
                           input string nm, output int got_cyc);
        int          exp_words, exp_cyc, cyc, we_cnt, wait_cnt;
        bit          exp_ab, seen;
        logic [31:0] exp_sum;
        logic [15:0] a, d;

        snapshot();
        exp_ab = (len != 0) && (abort_cyc >= 1) && (abort_cyc <= 2 * int'(len));
        if (exp_ab) begin
            exp_words = abort_cyc / 2;
            exp_cyc   = abort_cyc + 1;
        end else begin
            exp_words = int'(len);
            exp_cyc   = 2 * int'(len) + 1;
        end
        exp_sum = '0;
        for (int i = 0; i < exp_words; i++) begin
            a = src + 16'(i);
            d = dst + 16'(i);
            exp_sum    = exp_sum + ref_mem[a];
            ref_mem[d] = ref_mem[a];
        end

        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check({nm, ".ready"}, 64'(cmd_ready), 64'd1);

        cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_src = 16'($urandom); cmd_dst = 16'($urandom); cmd_len = 16'($urandom);

        cyc = 1; seen = 0; we_cnt = 0;
        while (cyc <= 2 * int'(len) + 5) begin
            abort = (cyc == abort_cyc);
            if (mem_we) we_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        got_cyc = cyc;
        check({nm, ".done_seen"}, 64'(seen), 64'd1);
        check({nm, ".latency"}, 64'(cyc), 64'(exp_cyc));
        check({nm, ".busy_in_done"}, 64'(busy), 64'd1);
        check({nm, ".ready_in_done"}, 64'(cmd_ready), 64'd0);
        check({nm, ".write_cycles"}, 64'(we_cnt), 64'(exp_words));
        @(posedge clk); #1;
        abort = 1'b0;
        check({nm, ".done_pulse"}, 64'(done), 64'd0);
        check({nm, ".words"}, 64'(words_copied), 64'(exp_words));
        check({nm, ".checksum"}, 64'(checksum), 64'(exp_sum));
        check({nm, ".aborted"}, 64'(aborted), 64'(exp_ab));
        compare_mem({nm, ".mem"});
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [31:0] base;
        int          abort_cyc;
        int          exp_words;
        logic [31:0] exp_sum;
        bit          exp_ab;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          got;
        logic [15:0] s, d, l;
        int          ac;

        vecs[0] = '{16'h0010, 16'h0040, 16'd4, 32'h1,   0, 4, 32'h0A,  1'b0, 9};
        vecs[1] = '{16'h0050, 16'h0060, 16'd0, 32'h0,   0, 0, 32'h0,   1'b0, 1};
        vecs[2] = '{16'hFFFE, 16'h0100, 16'd3, 32'h100, 0, 3, 32'h303, 1'b0, 7};
        vecs[3] = '{16'h0020, 16'h0021, 16'd3, 32'hAA,  0, 3, 32'h1FE, 1'b0, 7};
        vecs[4] = '{16'h0080, 16'h0090, 16'd8, 32'h10,  6, 3, 32'h33,  1'b1, 7};
        vecs[5] = '{16'h00A0, 16'h00B0, 16'd5, 32'h5,   5, 2, 32'h0B,  1'b1, 6};

        // Reset state
        #2 rst = 1'b1;
        #2;
        check("rst.ready", 64'(cmd_ready), 64'd1);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.we", 64'(mem_we), 64'd0);
        check("rst.addr", 64'(mem_addr), 64'd0);
        check("rst.wdata", 64'(mem_wdata), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.aborted", 64'(aborted), 64'd0);
        check("rst.checksum", 64'(checksum), 64'd0);
        check("rst.words", 64'(words_copied), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++)
                preload(vecs[v].src + 16'(i), vecs[v].base + 32'(i));
            run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].abort_cyc,
                    $sformatf("vec%0d", v), got);
            check($sformatf("vec%0d.tbl_cyc", v), 64'(got), 64'(vecs[v].exp_cyc));
            check($sformatf("vec%0d.tbl_words", v), 64'(words_copied), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d.tbl_sum", v), 64'(checksum), 64'(vecs[v].exp_sum));
            check($sformatf("vec%0d.tbl_ab", v), 64'(aborted), 64'(vecs[v].exp_ab));
            if (v == 3) begin
                check("overlap.mem21", 64'(mem[16'h0021]), 64'hAA);
                check("overlap.mem23", 64'(mem[16'h0023]), 64'hAA);
            end
        end

        // Reset in the middle of a copy: two words written, then rst.
        for (int i = 0; i < 8; i++) preload(16'h0200 + 16'(i), 32'h1000 + 32'(i));
        snapshot();
        ref_mem[16'h0300] = ref_mem[16'h0200];
        ref_mem[16'h0301] = ref_mem[16'h0201];
        cmd_valid = 1'b1; cmd_src = 16'h0200; cmd_dst = 16'h0300; cmd_len = 16'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst.we", 64'(mem_we), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.ready", 64'(cmd_ready), 64'd1);
        check("midrst.words", 64'(words_copied), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        compare_mem("midrst.mem");
        run_cmd(16'h0200, 16'h0300, 16'd8, 0, "post_rst", got);

        // Randomized copies, including wrap, overlap and aborts.
        for (int r = 0; r < 20; r++) begin
            l = 16'($urandom_range(0, 10));
            s = (r % 4 == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
            d = (r % 2 == 0) ? s + 16'($urandom_range(0, 12)) : 16'($urandom);
            ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * int'(l) + 1)) : 0;
            for (int i = 0; i < int'(l); i++) preload(s + 16'(i), $urandom);
            run_cmd(s, d, l, ac, $sformatf("rnd%0d", r), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
